mov_avg_ring: RTL and testbench

- Parametrised successor to the fixed 128-tap ADC moving sum.
- Keeps a recursive running sum (add newest sample, subtract the one leaving the window) over a circular sample RAM.
- Window length is run-time selectable: N = 2^win_log2, 1..2^LOG2_MAX_WIN.
- Emits the full sum and the window average on an AXI-Stream-style valid-only output. Sits between the ADC interface and the DSP/regulation path.

---
 rtl/mov_avg_pkg.sv | 18 +
 rtl/mov_avg_ring_if.sv | 8 +
 rtl/mov_avg_ram.sv | 24 ++
 rtl/mov_avg_ring.sv | 181 ++++++++++++++++++
 tb/tb_mov_avg_ring.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mov_avg_pkg.sv
// Shared types and elaboration helpers for the ring-buffer moving average.
package mov_avg_pkg;

   typedef enum logic [1:0] {
      FLUSH,
      FILL,
      RUN
   } state_e;

   function automatic int sum_width(input int data_w, input int log2_max_win);
      return data_w + log2_max_win;
   endfunction

   function automatic int unsigned clamp_win(input int unsigned req, input int unsigned max_win);
      return (req > max_win) ? max_win : req;
   endfunction

endpackage

// File: rtl/mov_avg_ring_if.sv
// Valid-only stream carrying the window average out of the filter.
interface mov_avg_ring_if;
   logic [31:0] tdata;
   logic        tvalid;

   modport master (output tdata, output tvalid);
   modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/mov_avg_ram.sv
// Simple dual-port sample store; read-first so a same-address write returns the old word.
module mov_avg_ram #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 7
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mov_avg_ring.sv
// Run-time sized moving sum/average over a circular sample RAM (N = 2^win_log2).
module mov_avg_ring
   import mov_avg_pkg::*;
#(
   parameter int DATA_W         = 24,
   parameter int LOG2_MAX_WIN   = 7,
   parameter int IN_OFFSET_BIN  = 1,
   parameter int OUT_OFFSET_BIN = 0,
   localparam int WL_W          = $clog2(LOG2_MAX_WIN + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [DATA_W-1:0]   i_adc_data,
   input  logic                i_adc_valid,
   input  logic [WL_W-1:0]     i_win_log2,
   input  logic                i_win_load,
   input  logic                i_clear,
   mov_avg_ring_if.master      adc_m_axis,
   output logic [31:0]         o_mov_sum_data,
   output logic                o_filled,
   output logic                o_busy
);

   localparam int SUM_W = sum_width(DATA_W, LOG2_MAX_WIN);
   localparam int AW    = LOG2_MAX_WIN;

   if (SUM_W > 32) begin : g_width_check
      $error("mov_avg_ring: DATA_W + LOG2_MAX_WIN must not exceed 32");
   end

   state_e                    state_q;
   logic [AW-1:0]             flush_addr_q;
   logic [AW-1:0]             wr_ptr_q;
   logic [AW:0]               fill_cnt_q;
   logic [WL_W-1:0]           win_q;
   logic signed [SUM_W-1:0]   sum_q;
   logic                      s1_valid_q;
   logic                      s1_emit_q;
   logic                      s1_use_old_q;
   logic signed [DATA_W-1:0]  s1_x_q;
   logic                      acc_valid_q;
   logic [31:0]               tdata_q;
   logic [31:0]               mov_sum_q;
   logic                      tvalid_q;
   logic                      filled_q;
   logic                      busy_q;

   logic                      restart_d;
   logic                      accept_d;
   logic [AW:0]               win_len_d;
   logic [AW:0]               fill_next_d;
   logic [DATA_W-1:0]         x_conv_d;
   logic [AW-1:0]             rd_addr_d;
   logic                      ram_we_d;
   logic [AW-1:0]             ram_waddr_d;
   logic [DATA_W-1:0]         ram_wdata_d;
   logic [DATA_W-1:0]         ram_rdata;
   logic signed [DATA_W-1:0]  old_x_d;
   logic signed [SUM_W-1:0]   sum_d;
   logic signed [DATA_W-1:0]  avg_s_d;
   logic [DATA_W-1:0]         avg_u_d;
   logic [31:0]               tdata_d;
   logic [WL_W-1:0]           win_load_d;

   always_comb begin
      restart_d   = i_win_load | i_clear;
      accept_d    = i_adc_valid & ~restart_d & (state_q != FLUSH);
      win_len_d   = (AW+1)'(1) << win_q;
      fill_next_d = fill_cnt_q + (AW+1)'(1);
      x_conv_d    = i_adc_data;
      if (IN_OFFSET_BIN != 0) x_conv_d[DATA_W-1] = ~i_adc_data[DATA_W-1];
      // N == depth makes rd_addr equal wr_ptr; the read-first RAM supplies the evicted sample
      rd_addr_d   = wr_ptr_q - win_len_d[AW-1:0];
      ram_we_d    = (state_q == FLUSH) | accept_d;
      ram_waddr_d = (state_q == FLUSH) ? flush_addr_q : wr_ptr_q;
      ram_wdata_d = (state_q == FLUSH) ? '0 : x_conv_d;
      win_load_d  = WL_W'(clamp_win(32'(i_win_log2), LOG2_MAX_WIN));
   end

   always_comb begin
      old_x_d = ram_rdata;
      sum_d   = sum_q + SUM_W'(s1_x_q) - (s1_use_old_q ? SUM_W'(old_x_d) : SUM_W'(0));
      avg_s_d = DATA_W'(sum_q >>> win_q);
      avg_u_d = {~avg_s_d[DATA_W-1], avg_s_d[DATA_W-2:0]};
      tdata_d = (OUT_OFFSET_BIN != 0) ? 32'(avg_u_d) : 32'(avg_s_d);
   end

   mov_avg_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (AW)
   ) u_ram (
      .clk_i   (i_clk),
      .we_i    (ram_we_d),
      .waddr_i (ram_waddr_d),
      .wdata_i (ram_wdata_d),
      .raddr_i (rd_addr_d),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= FLUSH;
         flush_addr_q <= '0;
         wr_ptr_q     <= '0;
         fill_cnt_q   <= '0;
         win_q        <= WL_W'(LOG2_MAX_WIN);
         sum_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_emit_q    <= 1'b0;
         s1_use_old_q <= 1'b0;
         s1_x_q       <= '0;
         acc_valid_q  <= 1'b0;
         tdata_q      <= '0;
         mov_sum_q    <= '0;
         tvalid_q     <= 1'b0;
         filled_q     <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         s1_valid_q   <= accept_d;
         s1_x_q       <= x_conv_d;
         s1_use_old_q <= (state_q == RUN);
         s1_emit_q    <= (state_q == RUN) || ((state_q == FILL) && (fill_next_d == win_len_d));
         // A restart kills every in-flight result so nothing is emitted during the flush
         acc_valid_q  <= s1_valid_q & s1_emit_q & ~restart_d;
         tvalid_q     <= acc_valid_q & ~restart_d;
         if (acc_valid_q && !restart_d) begin
            tdata_q   <= tdata_d;
            mov_sum_q <= 32'(sum_q);
         end

         if (restart_d || state_q == FLUSH) sum_q <= '0;
         else if (s1_valid_q)               sum_q <= sum_d;

         if (restart_d) begin
            if (i_win_load) win_q <= win_load_d;
            state_q      <= FLUSH;
            flush_addr_q <= '0;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            filled_q     <= 1'b0;
            busy_q       <= 1'b1;
         end else begin
            case (state_q)
               FLUSH: begin
                  wr_ptr_q     <= '0;
                  fill_cnt_q   <= '0;
                  flush_addr_q <= flush_addr_q + AW'(1);
                  if (flush_addr_q == '1) begin
                     state_q <= FILL;
                     busy_q  <= 1'b0;
                  end
               end
               FILL: begin
                  if (accept_d) begin
                     wr_ptr_q   <= wr_ptr_q + AW'(1);
                     fill_cnt_q <= fill_next_d;
                     if (fill_next_d == win_len_d) begin
                        state_q  <= RUN;
                        filled_q <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (accept_d) wr_ptr_q <= wr_ptr_q + AW'(1);
               end
               default: begin
                  state_q <= FLUSH;
                  busy_q  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign adc_m_axis.tdata  = tdata_q;
   assign adc_m_axis.tvalid = tvalid_q;
   assign o_mov_sum_data    = mov_sum_q;
   assign o_filled          = filled_q;
   assign o_busy            = busy_q;

endmodule

// File: tb/tb_mov_avg_ring.sv
// Bench for mov_avg_ring: window-sum reference model with timed scoreboard, plus directed vectors.
module tb_mov_avg_ring;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] adc_data  [2];
   logic        adc_valid [2];
   logic [2:0]  win_log2  [2];
   logic        win_load  [2];
   logic        clr       [2];
   logic [31:0] tdata     [2];
   logic [31:0] sum_o     [2];
   logic        tvalid    [2];
   logic        filled    [2];
   logic        busy      [2];

   always #5 clk = ~clk;

   mov_avg_ring_if if0 ();
   mov_avg_ring_if if1 ();

   mov_avg_ring #(.DATA_W(24), .LOG2_MAX_WIN(7), .IN_OFFSET_BIN(0), .OUT_OFFSET_BIN(0)) dut0 (
      .i_clk(clk), .i_rst(rst_n), .i_adc_data(adc_data[0]), .i_adc_valid(adc_valid[0]),
      .i_win_log2(win_log2[0]), .i_win_load(win_load[0]), .i_clear(clr[0]), .adc_m_axis(if0),
      .o_mov_sum_data(sum_o[0]), .o_filled(filled[0]), .o_busy(busy[0]));

   mov_avg_ring #(.DATA_W(24), .LOG2_MAX_WIN(5), .IN_OFFSET_BIN(1), .OUT_OFFSET_BIN(0)) dut1 (
      .i_clk(clk), .i_rst(rst_n), .i_adc_data(adc_data[1]), .i_adc_valid(adc_valid[1]),
      .i_win_log2(win_log2[1]), .i_win_load(win_load[1]), .i_clear(clr[1]), .adc_m_axis(if1),
      .o_mov_sum_data(sum_o[1]), .o_filled(filled[1]), .o_busy(busy[1]));

   assign tdata[0]  = if0.tdata;
   assign tvalid[0] = if0.tvalid;
   assign tdata[1]  = if1.tdata;
   assign tvalid[1] = if1.tvalid;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   typedef struct {
      int          due;
      logic [31:0] sum;
      logic [31:0] tdata;
   } exp_t;

   typedef struct {
      logic [23:0] x;
      logic [31:0] sum;
      logic [31:0] tdata;
   } vec_t;

   exp_t   expq [$];
   longint win_s [$];
   int     cur_d = 0;
   int     k_cur = 7;
   int     lgmax  [2] = '{7, 5};
   int     in_off [2] = '{0, 1};
   vec_t   tv [6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic void model_reset();
      win_s.delete();
      expq.delete();
      k_cur = lgmax[cur_d];
   endfunction

   // Restart at edge r: outputs that would land on or after r fall inside the flush.
   function automatic void model_restart(input int k, input int r);
      win_s.delete();
      k_cur = (k > lgmax[cur_d]) ? lgmax[cur_d] : k;
      while (expq.size() > 0 && expq[$].due >= r) void'(expq.pop_back());
   endfunction

   function automatic void model_push(input logic [23:0] x, input int a);
      logic [23:0] c;
      longint      s;
      longint      av;
      logic [23:0] a24;
      exp_t        e;
      c = (in_off[cur_d] != 0) ? (x ^ 24'h800000) : x;
      win_s.push_back(longint'($signed(c)));
      if (win_s.size() > (1 << k_cur)) void'(win_s.pop_front());
      if (win_s.size() == (1 << k_cur)) begin
         s = 0;
         foreach (win_s[i]) s += win_s[i];
         av      = s >>> k_cur;
         a24     = av[23:0];
         e.due   = a + 2;
         e.sum   = s[31:0];
         e.tdata = {{8{a24[23]}}, a24};
         expq.push_back(e);
      end
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (d != cur_d) begin
               if (tvalid[d] === 1'b1) begin
                  total++; bad++;
                  $display("FAIL idle_dut_tvalid dut%0d got=1 want=0", d);
               end
            end else if (tvalid[d] === 1'b1) begin
               if (expq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_tvalid got=1 want=0 cycle=%0d", cyc_n);
               end else begin
                  e = expq.pop_front();
                  chk("out_cycle", cyc_n, e.due);
                  chk("out_sum", sum_o[d], e.sum);
                  chk("out_tdata", tdata[d], e.tdata);
               end
            end else if (expq.size() > 0 && expq[0].due <= cyc_n) begin
               void'(expq.pop_front());
               total++; bad++;
               $display("FAIL missing_tvalid got=0 want=1 cycle=%0d", cyc_n);
            end
         end
      end
   end

   task automatic send(input int d, input logic [23:0] x);
      @(negedge clk);
      adc_valid[d] = 1'b1;
      adc_data[d]  = x;
      model_push(x, cyc_n + 1);
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      adc_valid[d] = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(negedge clk);
   endtask

   task automatic load(input int d, input int k, input bit with_sample, input bit also_clear);
      @(negedge clk);
      win_load[d]  = 1'b1;
      win_log2[d]  = 3'(k);
      clr[d]       = also_clear;
      adc_valid[d] = with_sample;
      adc_data[d]  = 24'($urandom);
      model_restart(k, cyc_n + 1);
      @(negedge clk);
      win_load[d]  = 1'b0;
      clr[d]       = 1'b0;
      adc_valid[d] = 1'b0;
   endtask

   task automatic clear_only(input int d);
      @(negedge clk);
      clr[d]       = 1'b1;
      win_log2[d]  = 3'($urandom);
      adc_valid[d] = 1'b1;
      adc_data[d]  = 24'($urandom);
      model_restart(k_cur, cyc_n + 1);
      @(negedge clk);
      clr[d]       = 1'b0;
      adc_valid[d] = 1'b0;
   endtask

   // Called on the first negedge after the restart; junk samples offered during the flush must be ignored.
   task automatic wait_flush(input int d);
      int n;
      int e;
      n = 1 << lgmax[d];
      e = 0;
      for (int i = 0; i < n; i++) begin
         if (busy[d] !== 1'b1 || tvalid[d] !== 1'b0 || filled[d] !== 1'b0) e++;
         @(negedge clk);
         adc_valid[d] = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         adc_data[d]  = 24'($urandom);
      end
      chk("flush_busy_window", e, 0);
      chk("flush_done", {31'b0, busy[d]}, 0);
   endtask

   task automatic rand_stream(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) != 0) send(d, 24'($urandom));
         else idle(d);
      end
      idle(d);
   endtask

   task automatic chk_reset_outputs(input int d, input string tag);
      chk({tag, "_tdata"},  tdata[d], 32'h0);
      chk({tag, "_tvalid"}, {31'b0, tvalid[d]}, 0);
      chk({tag, "_sum"},    sum_o[d], 32'h0);
      chk({tag, "_filled"}, {31'b0, filled[d]}, 0);
      chk({tag, "_busy"},   {31'b0, busy[d]}, 1);
   endtask

   initial begin : timeout
      #1_000_000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

   initial begin : stim
      tv[0] = '{24'h800000, 32'h00000000, 32'h00000000};
      tv[1] = '{24'h000000, 32'hFF800000, 32'hFF800000};
      tv[2] = '{24'hFFFFFF, 32'h007FFFFF, 32'h007FFFFF};
      tv[3] = '{24'h800001, 32'h00000001, 32'h00000001};
      tv[4] = '{24'h7FFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      tv[5] = '{24'hC00000, 32'h00400000, 32'h00400000};

      for (int d = 0; d < 2; d++) begin
         adc_data[d] = '0; adc_valid[d] = 1'b0; win_log2[d] = '0;
         win_load[d] = 1'b0; clr[d] = 1'b0;
      end
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset_outputs(0, "por0");
      chk_reset_outputs(1, "por1");
      rst_n = 1'b1;
      wait_flush(0);

      load(0, 2, 1'b0, 1'b0);
      wait_flush(0);
      for (int i = 1; i <= 5; i++) send(0, 24'(i));
      idle(0); drain();
      chk("w4_sum", sum_o[0], 32'd14);
      chk("w4_tdata", tdata[0], 32'd3);
      chk("w4_filled", {31'b0, filled[0]}, 1);

      load(0, 1, 1'b0, 1'b0);
      wait_flush(0);
      send(0, 24'hFFFFFD);
      send(0, 24'hFFFFFC);
      idle(0); drain();
      chk("neg_sum", sum_o[0], 32'hFFFFFFF9);
      chk("neg_floor_tdata", tdata[0], 32'hFFFFFFFC);

      load(0, 7, 1'b0, 1'b0);
      wait_flush(0);
      repeat (128) send(0, 24'h7FFFFF);
      idle(0); drain();
      chk("max_pos_sum", sum_o[0], 32'h3FFFFF80);
      chk("max_pos_tdata", tdata[0], 32'h007FFFFF);
      repeat (128) send(0, 24'h800000);
      idle(0); drain();
      chk("max_neg_sum", sum_o[0], 32'hC0000000);
      chk("max_neg_tdata", tdata[0], 32'hFF800000);

      rand_stream(0, 400);
      load(0, 3, 1'b0, 1'b0);
      wait_flush(0);
      rand_stream(0, 100);

      repeat (20) send(0, 24'($urandom));
      load(0, 1, 1'b1, 1'b0);
      wait_flush(0);
      send(0, 24'($urandom));
      send(0, 24'($urandom));
      idle(0); drain();
      chk("reload_filled", {31'b0, filled[0]}, 1);

      load(0, 3, 1'b0, 1'b0);
      repeat (50) @(negedge clk);
      chk("mid_flush_busy", {31'b0, busy[0]}, 1);
      load(0, 4, 1'b0, 1'b0);
      wait_flush(0);
      rand_stream(0, 60);

      load(0, 2, 1'b0, 1'b1);
      wait_flush(0);
      repeat (10) send(0, 24'($urandom));
      clear_only(0);
      wait_flush(0);
      rand_stream(0, 12);
      drain();

      cur_d = 1;
      model_reset();
      load(1, 7, 1'b0, 1'b0);
      wait_flush(1);
      repeat (31) send(1, 24'($urandom));
      idle(1); drain();
      chk("clamp_not_filled", {31'b0, filled[1]}, 0);
      send(1, 24'($urandom));
      idle(1); drain();
      chk("clamp_filled", {31'b0, filled[1]}, 1);
      rand_stream(1, 50);

      load(1, 0, 1'b0, 1'b0);
      wait_flush(1);
      for (int i = 0; i < 6; i++) begin
         send(1, tv[i].x);
         idle(1);
         @(posedge clk);
         @(posedge clk);
         @(negedge clk);
         chk("vec_tvalid", {31'b0, tvalid[1]}, 1);
         chk("vec_sum", sum_o[1], tv[i].sum);
         chk("vec_tdata", tdata[1], tv[i].tdata);
      end
      drain();

      cur_d = 0;
      model_reset();
      load(0, 5, 1'b0, 1'b0);
      wait_flush(0);
      repeat (40) send(0, 24'($urandom));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      adc_valid[0] = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs(0, "rst_run");
      @(negedge clk);
      rst_n = 1'b1;
      wait_flush(0);
      repeat (127) send(0, 24'($urandom));
      idle(0); drain();
      chk("post_rst_not_filled", {31'b0, filled[0]}, 0);
      send(0, 24'($urandom));
      idle(0); drain();
      chk("post_rst_filled", {31'b0, filled[0]}, 1);

      load(0, 2, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs(0, "rst_flush");
      @(negedge clk);
      rst_n = 1'b1;
      wait_flush(0);
      rand_stream(0, 160);
      drain();

      chk("scoreboard_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
